exe_stage_mc: RTL and testbench
===============================

EXE_STAGE_MC -- requirements
Module: exe_stage_mc

Interface
REQ-001 Parameter DATA_W, 32, datapath width; SHALL be ≥16 and a multiple of MUL_K.
REQ-002 Parameter MUL_K, 1, multiplier bits retired per cycle; legal values 1, 2, 4.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  upstream operation present; in_ready  out  1  stage accepts this cycle.
REQ-006 flush  in  1  synchronous kill of in-flight and held work.
REQ-007 wb_en_in, mem_read_in, mem_write_in, I  in  1 each  control bits, passed through.
REQ-008 exe_command_in  in  4  operation code; imm_rotate  in  4; imm_8  in  8; dest  in  4.
REQ-009 signed_immediate_24  in  24; PC_in, val_rn, val_rm  in  DATA_W; status_reg_in  in  4  {N,Z,C,V}.
REQ-010 out_valid  out  1; out_ready  in  1  downstream accepts.
REQ-011 wb_en_out, mem_read_out, mem_write_out  out  1; dest_out, status_bits_out  out  4.
REQ-012 branch_address, alu_res, val_rm_out  out  DATA_W, all registered; busy  out  1  multiply in progress.

Function
REQ-013 in_ready SHALL equal rst & !busy & !flush & (!out_valid | out_ready); accept = in_valid & in_ready.
REQ-014 Codes: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, MUL 1010; other codes SHALL give alu_res 0, flags unchanged.
REQ-015 Val2 SHALL be: mem_read_in|mem_write_in -> zero-extended {imm_rotate,imm_8}; else I=1 -> imm_8 zero-extended and rotated right by 2*imm_rotate; else val_rm.
REQ-016 ADC = rn+val2+C; SBC = rn-val2-!C; SUB/SBC carry = no-borrow; V = signed overflow; logic ops and MOV/MVN keep C,V; N = res[DATA_W-1], Z = (res==0) for all ops.
REQ-017 MUL SHALL produce low DATA_W bits of rn*rm (val2 ignored), update N,Z, keep C,V.
REQ-018 branch_address SHALL be PC_in + (sign-extended signed_immediate_24 << 2), modulo 2^DATA_W.
REQ-019 Non-MUL accepted at edge t SHALL present all outputs with out_valid=1 after edge t (latency 1).
REQ-020 FSM states IDLE, MUL: IDLE->MUL on accept of MUL; MUL stays DATA_W/MUL_K cycles, then ->IDLE with out_valid=1; latency DATA_W/MUL_K+1 edges; busy=1 exactly in MUL.
REQ-021 While out_valid=1 and out_ready=0 every output SHALL hold stable.
REQ-022 out_valid SHALL clear on out_ready=1 unless a new accept loads the register same edge (back-to-back, full throughput for non-MUL).
REQ-023 flush SHALL, at the edge, clear out_valid, abort MUL to IDLE, and block accept that cycle; flush wins over every other event.
REQ-024 Control bits, dest, val_rm SHALL be captured at accept and emitted unchanged with the result.

Reset
REQ-025 rst low SHALL immediately force: FSM IDLE, out_valid 0, busy 0, in_ready 0, every data/control output 0.
REQ-026 Reset asserted mid-multiply SHALL discard the operation; no output after release until a new accept.

Structure
REQ-027 Shared package exe_pkg SHALL hold opcode constants, flag bit indices, FSM state typedef.
REQ-028 Iterative shift-add multiplier SHALL be sub-module exe_mul_iter (start, operands, done, product); ALU and Val2 logic inline.

Verification
REQ-029 ADD rn=0x7FFFFFFF, I=1, imm_8=1, rot=0 -> next cycle alu_res=0x80000000, flags N=1 Z=0 C=0 V=1.
REQ-030 SBC rn=5, rm=5, I=0, C_in=0 -> alu_res=0xFFFFFFFF, N=1 C=0.
REQ-031 MUL rn=0x10001, rm=0x10001, MUL_K=1 -> busy 32 cycles, out_valid on 33rd edge, alu_res=0x00020001, C,V preserved.
REQ-032 PC_in=0x100, imm24=0xFFFFFF -> branch_address=0xFC.
REQ-033 Back-to-back ADDs with out_ready=0 two cycles -> outputs frozen, in_ready=0, second op emitted after release, none lost.
REQ-034 flush at MUL cycle 10, and rst low mid-MUL -> out_valid never asserts for it, busy 0 next cycle, next ADD accepted normally.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: opcodes, flag bit positions and FSM states.
package exe_pkg;

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1010;

  // Status vector layout is {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_K multiplier bits per cycle.
// done is asserted during the final step; product is valid in that same cycle.
module exe_mul_iter #(
  parameter int DATA_W = 32,
  parameter int MUL_K  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int STEPS = DATA_W / MUL_K;
  localparam int CNT_W = $clog2(STEPS) + 1;

  logic [DATA_W-1:0] acc_q, mcand_q, mplier_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              active_q;
  logic [DATA_W-1:0] partial;
  logic [DATA_W-1:0] acc_sum;

  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_K; j++) begin
      if (mplier_q[j]) partial = partial + (mcand_q << j);
    end
    acc_sum = acc_q + partial;
  end

  assign done    = active_q && (cnt_q == CNT_W'(STEPS - 1));
  assign product = acc_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (abort) begin
      active_q <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      acc_q    <= acc_sum;
      mcand_q  <= mcand_q << MUL_K;
      mplier_q <= mplier_q >> MUL_K;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (done) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/exe_stage_mc.sv
// Execute stage: single-cycle ALU plus an iterative multiplier, with a
// valid/ready output register that holds while downstream stalls.
module exe_stage_mc
  import exe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MUL_K  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              wb_en_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              I,
  input  logic [3:0]        exe_command_in,
  input  logic [3:0]        imm_rotate,
  input  logic [7:0]        imm_8,
  input  logic [3:0]        dest,
  input  logic [23:0]       signed_immediate_24,
  input  logic [DATA_W-1:0] PC_in,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [3:0]        status_reg_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic [3:0]        dest_out,
  output logic [3:0]        status_bits_out,
  output logic [DATA_W-1:0] branch_address,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] val_rm_out,
  output logic              busy
);

  localparam int MSB = DATA_W - 1;

  state_e            state_q, state_d;
  logic              out_valid_q, wb_q, mr_q, mw_q;
  logic [3:0]        dest_q, status_q;
  logic [1:0]        cv_q;
  logic [DATA_W-1:0] alu_res_q, branch_q, val_rm_q;

  logic              accept, is_mul, mul_done, mul_fin;
  logic [DATA_W-1:0] mul_product;
  logic [DATA_W-1:0] imm_ext, imm_rot, mem_imm, val2, br_off, alu_d;
  logic [DATA_W:0]   sum_w;
  logic [3:0]        flags_d;
  logic              c_in, c_d, v_d, known_op;
  int                rot_amt;

  assign is_mul   = (exe_command_in == OP_MUL);
  assign in_ready = rst && !busy && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign mul_fin  = (state_q == ST_MUL) && mul_done && !flush;
  assign c_in     = status_reg_in[FLAG_C];

  assign imm_ext = DATA_W'(imm_8);
  assign mem_imm = DATA_W'({imm_rotate, imm_8});

  always_comb begin
    rot_amt = (2 * int'(imm_rotate)) % DATA_W;
    imm_rot = (imm_ext >> rot_amt) | (imm_ext << (DATA_W - rot_amt));
    if (mem_read_in || mem_write_in) val2 = mem_imm;
    else if (I)                      val2 = imm_rot;
    else                             val2 = val_rm;
  end

  // Subtraction is done as rn + ~val2 + carry so the carry-out is the no-borrow flag
  always_comb begin
    sum_w    = '0;
    alu_d    = '0;
    c_d      = status_reg_in[FLAG_C];
    v_d      = status_reg_in[FLAG_V];
    known_op = 1'b1;
    case (exe_command_in)
      OP_MOV: alu_d = val2;
      OP_MVN: alu_d = ~val2;
      OP_ADD, OP_ADC: begin
        sum_w = {1'b0, val_rn} + {1'b0, val2}
              + {{DATA_W{1'b0}}, (exe_command_in == OP_ADC) & c_in};
        alu_d = sum_w[DATA_W-1:0];
        c_d   = sum_w[DATA_W];
        v_d   = (val_rn[MSB] == val2[MSB]) && (alu_d[MSB] != val_rn[MSB]);
      end
      OP_SUB, OP_SBC: begin
        sum_w = {1'b0, val_rn} + {1'b0, ~val2}
              + {{DATA_W{1'b0}}, (exe_command_in == OP_SUB) | c_in};
        alu_d = sum_w[DATA_W-1:0];
        c_d   = sum_w[DATA_W];
        v_d   = (val_rn[MSB] != val2[MSB]) && (alu_d[MSB] != val_rn[MSB]);
      end
      OP_AND:  alu_d = val_rn & val2;
      OP_ORR:  alu_d = val_rn | val2;
      OP_EOR:  alu_d = val_rn ^ val2;
      default: known_op = 1'b0;
    endcase
    flags_d = known_op ? {alu_d[MSB], alu_d == '0, c_d, v_d} : status_reg_in;
  end

  generate
    if (DATA_W > 26) begin : g_br_wide
      assign br_off = {{(DATA_W-26){signed_immediate_24[23]}}, signed_immediate_24, 2'b00};
    end else begin : g_br_narrow
      assign br_off = {signed_immediate_24[DATA_W-3:0], 2'b00};
    end
  endgenerate

  exe_mul_iter #(
    .DATA_W(DATA_W),
    .MUL_K (MUL_K)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst),
    .start  (accept && is_mul),
    .abort  (flush),
    .a      (val_rn),
    .b      (val_rm),
    .done   (mul_done),
    .product(mul_product)
  );

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      ST_IDLE: if (accept && is_mul) state_d = ST_MUL;
      ST_MUL: begin
        busy = 1'b1;
        if (flush || mul_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      wb_q        <= 1'b0;
      mr_q        <= 1'b0;
      mw_q        <= 1'b0;
      dest_q      <= '0;
      status_q    <= '0;
      cv_q        <= '0;
      alu_res_q   <= '0;
      branch_q    <= '0;
      val_rm_q    <= '0;
    end else begin
      if (flush)                  out_valid_q <= 1'b0;
      else if (accept && !is_mul) out_valid_q <= 1'b1;
      else if (mul_fin)           out_valid_q <= 1'b1;
      else if (out_ready)         out_valid_q <= 1'b0;

      // Accept only happens once the register is free, so capturing a MUL's side fields early is safe
      if (accept) begin
        wb_q     <= wb_en_in;
        mr_q     <= mem_read_in;
        mw_q     <= mem_write_in;
        dest_q   <= dest;
        val_rm_q <= val_rm;
        branch_q <= PC_in + br_off;
        cv_q     <= {status_reg_in[FLAG_C], status_reg_in[FLAG_V]};
        if (!is_mul) begin
          alu_res_q <= alu_d;
          status_q  <= flags_d;
        end
      end
      if (mul_fin) begin
        alu_res_q <= mul_product;
        status_q  <= {mul_product[MSB], mul_product == '0, cv_q};
      end
    end
  end

  assign out_valid       = out_valid_q;
  assign wb_en_out       = wb_q;
  assign mem_read_out    = mr_q;
  assign mem_write_out   = mw_q;
  assign dest_out        = dest_q;
  assign status_bits_out = status_q;
  assign branch_address  = branch_q;
  assign alu_res         = alu_res_q;
  assign val_rm_out      = val_rm_q;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc with an arithmetic reference model and a
// per-cycle compare process on the handshake, busy and output stream.
module tb_exe_stage_mc;

  localparam int W = 32;
  localparam int K = 1;
  localparam int STEPS = W / K;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic        wb_en_in = 1'b0, mem_read_in = 1'b0, mem_write_in = 1'b0, I = 1'b0;
  logic [3:0]  exe_command_in = '0, imm_rotate = '0, dest = '0, status_reg_in = '0;
  logic [7:0]  imm_8 = '0;
  logic [23:0] signed_immediate_24 = '0;
  logic [W-1:0] PC_in = '0, val_rn = '0, val_rm = '0;
  logic        in_ready, out_valid, wb_en_out, mem_read_out, mem_write_out, busy;
  logic [3:0]  dest_out, status_bits_out;
  logic [W-1:0] branch_address, alu_res, val_rm_out;

  exe_stage_mc #(.DATA_W(W), .MUL_K(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .wb_en_in(wb_en_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .I(I),
    .exe_command_in(exe_command_in), .imm_rotate(imm_rotate), .imm_8(imm_8), .dest(dest),
    .signed_immediate_24(signed_immediate_24), .PC_in(PC_in), .val_rn(val_rn),
    .val_rm(val_rm), .status_reg_in(status_reg_in), .out_valid(out_valid),
    .out_ready(out_ready), .wb_en_out(wb_en_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .dest_out(dest_out), .status_bits_out(status_bits_out),
    .branch_address(branch_address), .alu_res(alu_res), .val_rm_out(val_rm_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  typedef struct {
    logic [31:0] alu;
    logic [3:0]  flags;
    logic [31:0] br;
    logic [31:0] rm;
    logic [3:0]  dst;
    logic        wb, mr, mw;
    logic        is_mul;
  } exp_t;

  function automatic logic ovf(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Reference: ARM-style semantics from plain wide arithmetic on the current inputs
  function automatic exp_t model_now();
    exp_t e;
    logic [31:0] v2, res;
    logic [63:0] ua, ub, u;
    longint sa, sb, cl, nc;
    logic cf, vf, known;
    if (mem_read_in || mem_write_in) v2 = {20'd0, imm_rotate, imm_8};
    else if (I) begin
      v2 = {24'd0, imm_8};
      for (int k = 0; k < 2 * int'(imm_rotate); k++) v2 = {v2[0], v2[31:1]};
    end else v2 = val_rm;
    ua = {32'd0, val_rn};
    ub = {32'd0, v2};
    sa = longint'($signed(val_rn));
    sb = longint'($signed(v2));
    cl = longint'(status_reg_in[1]);
    nc = 1 - cl;
    cf = status_reg_in[1];
    vf = status_reg_in[0];
    known = 1'b1;
    res = '0;
    case (exe_command_in)
      4'd1:  res = v2;
      4'd9:  res = ~v2;
      4'd2:  begin u = ua + ub; res = u[31:0]; cf = u[32]; vf = ovf(sa + sb); end
      4'd3:  begin u = ua + ub + 64'(cl); res = u[31:0]; cf = u[32]; vf = ovf(sa + sb + cl); end
      4'd4:  begin res = val_rn - v2; cf = (ua >= ub); vf = ovf(sa - sb); end
      4'd5:  begin res = val_rn - v2 - 32'(nc); cf = (ua >= ub + 64'(nc)); vf = ovf(sa - sb - nc); end
      4'd6:  res = val_rn & v2;
      4'd7:  res = val_rn | v2;
      4'd8:  res = val_rn ^ v2;
      4'd10: begin u = ua * {32'd0, val_rm}; res = u[31:0]; end
      default: known = 1'b0;
    endcase
    e.alu    = res;
    e.flags  = known ? {res[31], res == 0, cf, vf} : status_reg_in;
    e.br     = PC_in + 32'(longint'($signed(signed_immediate_24)) * 4);
    e.rm     = val_rm;
    e.dst    = dest;
    e.wb     = wb_en_in;
    e.mr     = mem_read_in;
    e.mw     = mem_write_in;
    e.is_mul = (exe_command_in == 4'd10);
    return e;
  endfunction

  // Compare process: handshake/busy expectations and in-order output stream
  exp_t q[$];
  int   mul_left = 0;
  logic exp_valid = 1'b0;
  logic stall_prev = 1'b0;
  logic [107:0] snap;

  always @(negedge clk) begin : cmp
    exp_t e, got;
    logic exp_rdy, nxt_valid, acc;
    if (!rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      q.delete();
      mul_left = 0;
      exp_valid = 1'b0;
      stall_prev = 1'b0;
    end else begin
      exp_rdy = !(mul_left > 0) && !flush && (!exp_valid || out_ready);
      chk("out_valid", out_valid, exp_valid);
      chk("busy", busy, mul_left > 0);
      chk("in_ready", in_ready, exp_rdy);
      if (stall_prev && out_valid)
        chk("stall_hold", {alu_res, status_bits_out, branch_address, val_rm_out, dest_out,
                           wb_en_out, mem_read_out, mem_write_out, 1'b0}, snap);
      stall_prev = out_valid && !out_ready && !flush;
      snap = {alu_res, status_bits_out, branch_address, val_rm_out, dest_out,
              wb_en_out, mem_read_out, mem_write_out, 1'b0};
      if (out_valid && out_ready && !flush) begin
        if (q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          e = q.pop_front();
          got.alu = alu_res;
          $display("xfer alu=%08h flags=%h br=%08h dest=%h mul=%0d", alu_res,
                   status_bits_out, branch_address, dest_out, e.is_mul);
          chk("alu_res", alu_res, e.alu);
          chk("flags", status_bits_out, e.flags);
          chk("branch", branch_address, e.br);
          chk("val_rm_out", val_rm_out, e.rm);
          chk("ctrl", {dest_out, wb_en_out, mem_read_out, mem_write_out},
                      {e.dst, e.wb, e.mr, e.mw});
        end
      end
      if (flush) begin
        q.delete();
        mul_left = 0;
        exp_valid = 1'b0;
      end else begin
        acc = in_valid && exp_rdy;
        nxt_valid = exp_valid && !out_ready;
        if (mul_left == 1) nxt_valid = 1'b1;
        if (mul_left > 0) mul_left--;
        if (acc) begin
          e = model_now();
          q.push_back(e);
          if (e.is_mul) mul_left = STEPS;
          else nxt_valid = 1'b1;
        end
        exp_valid = nxt_valid;
      end
    end
  end

  task automatic set_op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                        input logic i, input logic [3:0] rot, input logic [7:0] imm,
                        input logic [3:0] st);
    exe_command_in = cmd; val_rn = rn; val_rm = rm; I = i; imm_rotate = rot; imm_8 = imm;
    status_reg_in = st; dest = rn[3:0] ^ cmd; PC_in = rn ^ 32'h1000;
    signed_immediate_24 = rm[23:0]; wb_en_in = cmd[0]; mem_read_in = 0; mem_write_in = 0;
  endtask

  // Holds in_valid until accepted (bounded), returns #1 after the accept edge
  task automatic handshake();
    int n;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                      input logic i, input logic [3:0] rot, input logic [7:0] imm,
                      input logic [3:0] st);
    set_op(cmd, rn, rm, i, rot, imm, st);
    handshake();
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk(name, seen, 0);
  endtask

  typedef struct {
    logic [3:0] cmd; logic [31:0] rn, rm; logic i; logic [7:0] imm; logic [3:0] st;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] cmd, input logic [31:0] rn,
                              input logic [31:0] rm, input logic i, input logic [7:0] imm,
                              input logic [3:0] st);
    vec_t v;
    v.cmd = cmd; v.rn = rn; v.rm = rm; v.i = i; v.imm = imm; v.st = st;
    return v;
  endfunction

  vec_t vt[8];

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int nb, n;
    vt[0] = mk(4'd9, 32'h0, 32'h0F0F0F0F, 0, 8'h00, 4'b0000);
    vt[1] = mk(4'd6, 32'hFF00FF00, 32'h0F0F0F0F, 0, 8'h00, 4'b0011);
    vt[2] = mk(4'd7, 32'hFF00FF00, 32'h0F0F0F0F, 0, 8'h00, 4'b0000);
    vt[3] = mk(4'd8, 32'h12345678, 32'h12345678, 0, 8'h00, 4'b0001);
    vt[4] = mk(4'd3, 32'hFFFFFFFF, 32'h0, 1, 8'h00, 4'b0010);
    vt[5] = mk(4'd4, 32'h80000000, 32'h0, 1, 8'h01, 4'b0000);
    vt[6] = mk(4'd4, 32'h9, 32'h9, 0, 8'h00, 4'b0000);
    vt[7] = mk(4'd2, 32'h1, 32'h2, 0, 8'h00, 4'b1111);

    // Reset state
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_outputs", {out_valid, busy, alu_res, branch_address, val_rm_out, status_bits_out,
                          dest_out, wb_en_out, mem_read_out, mem_write_out}, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    send(4'd2, 32'h7FFFFFFF, 32'h0, 1, 4'd0, 8'h01, 4'b0000);
    chk("add_ovf_valid", out_valid, 1);
    chk("add_ovf_res", alu_res, 32'h80000000);
    chk("add_ovf_flags", status_bits_out, 4'b1001);

    send(4'd5, 32'h5, 32'h5, 0, 4'd0, 8'h00, 4'b0000);
    chk("sbc_res", alu_res, 32'hFFFFFFFF);
    chk("sbc_flags", status_bits_out, 4'b1000);

    set_op(4'd1, 32'h0, 32'h0, 1, 4'd4, 8'hFF, 4'b0011);
    PC_in = 32'h100; signed_immediate_24 = 24'hFFFFFF;
    handshake();
    chk("branch_neg", branch_address, 32'hFC);
    chk("mov_rot_res", alu_res, 32'hFF000000);
    chk("mov_rot_flags", status_bits_out, 4'b1011);

    send(4'd0, 32'h55, 32'h66, 0, 4'd0, 8'h00, 4'b0110);
    chk("bad_op_res", alu_res, 0);
    chk("bad_op_flags", status_bits_out, 4'b0110);
    send(4'd15, 32'h55, 32'h66, 1, 4'd1, 8'h07, 4'b1001);

    set_op(4'd2, 32'h100, 32'hDEAD, 1, 4'd3, 8'h45, 4'b0000);
    mem_read_in = 1'b1;
    handshake();
    chk("mem_val2_res", alu_res, 32'h445);

    // Back-to-back, one accept per cycle
    for (int v = 0; v < 8; v++) begin
      set_op(vt[v].cmd, vt[v].rn, vt[v].rm, vt[v].i, 4'd0, vt[v].imm, vt[v].st);
      in_valid = 1'b1;
      #1;
      chk("b2b_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("b2b_last_res", alu_res, 32'h3);
    chk("b2b_last_flags", status_bits_out, 4'b0000);

    // Multiply latency and result
    set_op(4'd10, 32'h10001, 32'h10001, 1, 4'd2, 8'h33, 4'b0011);
    handshake();
    nb = 0; n = 0;
    while (!out_valid && n < 100) begin
      if (busy) nb++;
      @(posedge clk); #1; n++;
    end
    chk("mul_busy_cycles", nb, 32);
    chk("mul_latency", n + 1, 33);
    chk("mul_res", alu_res, 32'h00020001);
    chk("mul_flags", status_bits_out, 4'b0011);
    chk("mul_busy_after", busy, 0);
    send(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 4'd0, 8'h00, 4'b0000);
    send(4'd10, 32'h10000, 32'h10000, 0, 4'd0, 8'h00, 4'b0001);
    repeat (40) @(posedge clk);
    #1;

    // Stall: second op waits, first held
    out_ready = 1'b0;
    send(4'd2, 32'h1, 32'h0, 1, 4'd0, 8'h01, 4'b0000);
    set_op(4'd2, 32'hA, 32'h0, 1, 4'd0, 8'h05, 4'b0000);
    in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_res", alu_res, 32'h2);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("release_res", alu_res, 32'hF);
    chk("release_valid", out_valid, 1);
    @(posedge clk); #1;

    // Flush a held result
    out_ready = 1'b0;
    send(4'd2, 32'h40, 32'h0, 1, 4'd0, 8'h02, 4'b0000);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_held_valid", out_valid, 0);
    out_ready = 1'b1;

    // Flush mid-multiply
    send(4'd10, 32'h3, 32'h7, 0, 4'd0, 8'h00, 4'b0000);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    expect_quiet("flush_mul_quiet", 40);
    send(4'd2, 32'd20, 32'h0, 1, 4'd0, 8'h02, 4'b0000);
    chk("post_flush_add", alu_res, 32'd22);
    @(posedge clk); #1;

    // Reset mid-multiply, asserted between edges
    send(4'd10, 32'h3, 32'h7, 0, 4'd0, 8'h00, 4'b0000);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    chk("async_rst", {busy, out_valid, in_ready, alu_res}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    expect_quiet("rst_mul_quiet", 40);
    send(4'd2, 32'd30, 32'h0, 1, 4'd0, 8'h03, 4'b0000);
    chk("post_rst_add", alu_res, 32'd33);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
